sub_d_arb: RTL and testbench
============================

// Module: sub_d_arb
// PURPOSE
//  Round-robin scheduler that shares one sub_d datapath instance among NUM_REQ requesters.
//  - Accepts a 3-bit operand from the winning requester.
//  - Drives the operand onto the sub_d inputs and holds it stable for HOLD_CYC cycles.
//  - Captures the sub_d outputs, then returns them with the requester ID on a valid/ready response port.
//  - Sits between the request fabric and the sub_d/sub_sub_d pair. It is the only driver of sub_d inputs.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 1..16
//  HOLD_CYC  1   cycles operands are held on the datapath before capture, 1..15
//  REQ_W     max(1,$clog2(NUM_REQ))   localparam: width of the requester ID
// PORTS
//  clk_d            in   1          single clock, rising edge
//  rst_n_d          in   1          asynchronous, active-low reset
//  req_vld_d        in   NUM_REQ    per-requester request valid
//  req_op_d         in   3*NUM_REQ  per-requester operand; slice k = {testi3,testi2,testi1}
//  req_rdy_d        out  NUM_REQ    one-hot grant/accept pulse
//  dp_testi1_d      out  1          to sub_d testi1_d
//  dp_testi2_d      out  1          to sub_d testi2_d
//  dp_testi3_d      out  1          to sub_d testi3_d
//  dp_testo1_d      in   1          from sub_d testo1_d
//  dp_testo2_d      in   2          from sub_d testo2_d
//  dp_testo1_sub_d  in   1          from sub_d testo1_sub_d
//  rsp_vld_d        out  1          response valid
//  rsp_rdy_d        in   1          response ready
//  rsp_id_d         out  REQ_W      index of the requester being answered
//  rsp_data_d       out  4          {testo1_sub, testo2[1:0], testo1}
//  busy_d           out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Reset state (rst_n_d=0, asynchronous):
//  - state=IDLE, ptr=NUM_REQ-1, so requester 0 wins first.
//  - hold counter=0.
//  - All outputs 0, including dp_testi*_d, rsp_*_d and req_rdy_d.
//  - A reset mid-transaction discards the transaction; no response is ever issued for it.
//  FSM (IDLE -> HOLD -> RESP -> IDLE):
//  - IDLE:
//    - If |req_vld_d, pick the first valid requester searching ptr+1, ptr+2, ... modulo NUM_REQ.
//    - req_rdy_d[k]=1 combinationally in that same cycle; k is the only bit set.
//    - Register op slice k into dp_testi*_d and k into rsp_id_d; go to HOLD.
//    - With no valid request, stay in IDLE with req_rdy_d=0.
//  - HOLD:
//    - Counter runs 0..HOLD_CYC-1.
//    - On the last count, register {dp_testo1_sub_d, dp_testo2_d, dp_testo1_d} into rsp_data_d.
//    - Set rsp_vld_d=1 and go to RESP.
//  - RESP:
//    - rsp_vld_d=1. rsp_data_d and rsp_id_d are stable until the handshake.
//    - On rsp_vld_d & rsp_rdy_d: rsp_vld_d clears, ptr updates to k, go to IDLE.
//    - No grant is issued in RESP; grants are issued only from IDLE.
//  Timing:
//  - Latency: grant at cycle 0, rsp_vld_d first high at cycle HOLD_CYC+1.
//  - Minimum request period is HOLD_CYC+2 cycles.
//  Requester and datapath rules:
//  - A requester must hold req_op_d stable while req_vld_d is high.
//  - A requester may drop req_vld_d before it is granted; it then loses its turn with no side effects.
//  - dp_testi*_d keep the last operand after the response; they are not zeroed. This avoids datapath toggling.
//  - NUM_REQ=1: ptr stays 0 and the design degenerates to single-requester sequencing.
//  - The ptr wrap from NUM_REQ-1 to 0 is handled by the modulo search.
//  - Simultaneous requests are resolved by the ptr search only; there is no fixed priority.
//  - No output depends combinationally on rsp_rdy_d.
// STRUCTURE
//  Package sub_d_arb_pkg:
//  - state encoding: IDLE=2'd0, HOLD=2'd1, RESP=2'd2 (2'd3 is illegal and maps to IDLE).
//  - RSP_W=4.
//  - rsp_data field offsets: TESTO1=0, TESTO2=1..2, TESTO1_SUB=3.
//  - OP_W=3.
//  Sub-module rr_pick_d:
//  - Combinational round-robin picker.
//  - Inputs: req vector and ptr. Outputs: one-hot grant, grant index and any_req.
//  - Parameterised by NUM_REQ.
// TESTING
//  Bench uses a behavioural sub_d model whose sub_sub_d stub returns testo1_sub = testi2.
//  1 Reset: pulse rst_n_d low during HOLD -> all outputs 0 immediately, no rsp_vld_d afterwards, first grant goes to req 0.
//  2 Single request: req_vld_d=4'b0001, op=3'b011, HOLD_CYC=1 -> req_rdy_d=4'b0001 at cycle 0; rsp_vld_d at cycle 2 with rsp_id_d=0 and rsp_data_d=4'b1100.
//  3 Round-robin: req_vld_d=4'b1111 held, rsp_rdy_d=1 -> grant order 0,1,2,3,0; rsp_id_d follows the same order; one grant every 3 cycles.
//  4 Backpressure: rsp_rdy_d=0 for 5 cycles -> rsp_vld_d, rsp_data_d and rsp_id_d stable; req_rdy_d=0; busy_d=1 throughout.
//  5 Wrap: ptr=3, req_vld_d=4'b0101 -> grant req 0, then req 2.
//  6 HOLD_CYC=3 build: single request -> rsp_vld_d first high at cycle 4; dp_testi*_d stable for cycles 1..3.

Source files
------------

// File: rtl/sub_d_arb_pkg.sv
// Shared types and field layout for the sub_d round-robin scheduler.
package sub_d_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OP_W           = 3;
    localparam int RSP_W          = 4;
    localparam int RSP_TESTO1     = 0;
    localparam int RSP_TESTO2_LO  = 1;
    localparam int RSP_TESTO1_SUB = 3;

    // Assemble the response word from the individual sub_d outputs.
    function automatic logic [RSP_W-1:0] pack_rsp(
        input logic       testo1_sub,
        input logic [1:0] testo2,
        input logic       testo1
    );
        logic [RSP_W-1:0] v;
        v                      = '0;
        v[RSP_TESTO1]          = testo1;
        v[RSP_TESTO2_LO +: 2]  = testo2;
        v[RSP_TESTO1_SUB]      = testo1_sub;
        return v;
    endfunction

endpackage

// File: rtl/sub_d_arb_rr_pick_d.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module rr_pick_d
    import sub_d_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [REQ_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [REQ_W-1:0]   o_idx,
    output logic               o_any
);

    int w_dist;
    int w_best;

    // Distance of requester k from the slot after ptr; the closest valid one wins.
    always_comb begin
        w_best = NUM_REQ;
        w_dist = 0;
        o_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k > int'(i_ptr)) begin
                w_dist = k - int'(i_ptr) - 1;
            end else begin
                w_dist = k + NUM_REQ - int'(i_ptr) - 1;
            end
            if (i_req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = REQ_W'(k);
            end
        end
    end

    // Expand the winning index into a one-hot grant.
    always_comb begin
        o_any = |i_req;
        o_gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_gnt[k] = o_any && (o_idx == REQ_W'(k));
        end
    end

endmodule

// File: rtl/sub_d_arb.sv
// Round-robin scheduler sharing one sub_d datapath among NUM_REQ requesters.
//
//  state | meaning
//  IDLE  | waiting for a request; grants combinationally and latches the operand
//  HOLD  | operand held on the datapath for HOLD_CYC cycles, then result captured
//  RESP  | response valid, waiting for rsp_rdy_d
module sub_d_arb
    import sub_d_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int HOLD_CYC = 1,
    localparam int REQ_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_d,
    input  logic                    rst_n_d,
    input  logic [NUM_REQ-1:0]      req_vld_d,
    input  logic [OP_W*NUM_REQ-1:0] req_op_d,
    output logic [NUM_REQ-1:0]      req_rdy_d,
    output logic                    dp_testi1_d,
    output logic                    dp_testi2_d,
    output logic                    dp_testi3_d,
    input  logic                    dp_testo1_d,
    input  logic [1:0]              dp_testo2_d,
    input  logic                    dp_testo1_sub_d,
    output logic                    rsp_vld_d,
    input  logic                    rsp_rdy_d,
    output logic [REQ_W-1:0]        rsp_id_d,
    output logic [RSP_W-1:0]        rsp_data_d,
    output logic                    busy_d
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [REQ_W-1:0]   r_ptr;
    logic [3:0]         r_cnt;
    logic [OP_W-1:0]    r_op;
    logic [REQ_W-1:0]   r_id;
    logic [RSP_W-1:0]   r_data;
    logic               r_vld;

    logic [NUM_REQ-1:0] w_gnt;
    logic [REQ_W-1:0]   w_idx;
    logic               w_any;
    logic               w_take;
    logic               w_cnt_last;
    logic [OP_W-1:0]    w_op;

    rr_pick_d #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req (req_vld_d),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_take     = (r_state == IDLE) && w_any;
    assign w_cnt_last = (r_cnt == 4'(HOLD_CYC - 1));

    // Select the operand slice of the winning requester.
    always_comb begin
        w_op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_op = req_op_d[k*OP_W +: OP_W];
            end
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)      w_state_nxt = HOLD;
            HOLD:    if (w_cnt_last) w_state_nxt = RESP;
            RESP:    if (rsp_rdy_d)  w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, hold counter, response capture and pointer update.
    always_ff @(posedge clk_d or negedge rst_n_d) begin
        if (!rst_n_d) begin
            r_ptr  <= REQ_W'(NUM_REQ - 1);
            r_cnt  <= '0;
            r_op   <= '0;
            r_id   <= '0;
            r_data <= '0;
            r_vld  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op  <= w_op;
                        r_id  <= w_idx;
                        r_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (w_cnt_last) begin
                        r_data <= pack_rsp(dp_testo1_sub_d, dp_testo2_d, dp_testo1_d);
                        r_vld  <= 1'b1;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_rdy_d) begin
                        r_vld <= 1'b0;
                        r_ptr <= r_id;
                    end
                end
                default: r_vld <= 1'b0;
            endcase
        end
    end

    // Grant is combinational in IDLE only, and forced low while reset is asserted.
    assign req_rdy_d   = (w_take && rst_n_d) ? w_gnt : '0;
    assign dp_testi1_d = r_op[0];
    assign dp_testi2_d = r_op[1];
    assign dp_testi3_d = r_op[2];
    assign rsp_vld_d   = r_vld;
    assign rsp_id_d    = r_id;
    assign rsp_data_d  = r_data;
    assign busy_d      = (r_state != IDLE);

endmodule

// File: tb/tb_sub_d_arb.sv
// Bench for sub_d_arb: directed scenarios plus randomized traffic against a transaction model.
module tb_sub_d_arb;

    localparam int N  = 4;
    localparam int HC = 1;

    logic         clk_d = 1'b0;
    logic         rst_n_d;
    logic [N-1:0] req_vld_d;
    logic [3*N-1:0] req_op_d;
    logic [N-1:0] req_rdy_d;
    logic         dp_testi1_d, dp_testi2_d, dp_testi3_d;
    logic         dp_testo1_d;
    logic [1:0]   dp_testo2_d;
    logic         dp_testo1_sub_d;
    logic         rsp_vld_d;
    logic         rsp_rdy_d;
    logic [1:0]   rsp_id_d;
    logic [3:0]   rsp_data_d;
    logic         busy_d;

    logic [N-1:0] req_vld_3;
    logic [3*N-1:0] req_op_3;
    logic [N-1:0] req_rdy_3;
    logic         dp_testi1_3, dp_testi2_3, dp_testi3_3;
    logic         dp_testo1_3;
    logic [1:0]   dp_testo2_3;
    logic         dp_testo1_sub_3;
    logic         rsp_vld_3;
    logic         rsp_rdy_3;
    logic [1:0]   rsp_id_3;
    logic [3:0]   rsp_data_3;
    logic         busy_3;

    always #5 clk_d = ~clk_d;

    // Behavioural sub_d; its sub_sub_d stub returns testo1_sub = testi2.
    assign dp_testo1_d     = dp_testi1_d ^ dp_testi2_d;
    assign dp_testo2_d     = {dp_testi2_d, dp_testi1_d & dp_testi3_d};
    assign dp_testo1_sub_d = dp_testi2_d;
    assign dp_testo1_3     = dp_testi1_3 ^ dp_testi2_3;
    assign dp_testo2_3     = {dp_testi2_3, dp_testi1_3 & dp_testi3_3};
    assign dp_testo1_sub_3 = dp_testi2_3;

    sub_d_arb #(.NUM_REQ(N), .HOLD_CYC(HC)) dut (
        .clk_d(clk_d), .rst_n_d(rst_n_d),
        .req_vld_d(req_vld_d), .req_op_d(req_op_d), .req_rdy_d(req_rdy_d),
        .dp_testi1_d(dp_testi1_d), .dp_testi2_d(dp_testi2_d), .dp_testi3_d(dp_testi3_d),
        .dp_testo1_d(dp_testo1_d), .dp_testo2_d(dp_testo2_d), .dp_testo1_sub_d(dp_testo1_sub_d),
        .rsp_vld_d(rsp_vld_d), .rsp_rdy_d(rsp_rdy_d), .rsp_id_d(rsp_id_d),
        .rsp_data_d(rsp_data_d), .busy_d(busy_d)
    );

    sub_d_arb #(.NUM_REQ(N), .HOLD_CYC(3)) dut3 (
        .clk_d(clk_d), .rst_n_d(rst_n_d),
        .req_vld_d(req_vld_3), .req_op_d(req_op_3), .req_rdy_d(req_rdy_3),
        .dp_testi1_d(dp_testi1_3), .dp_testi2_d(dp_testi2_3), .dp_testi3_d(dp_testi3_3),
        .dp_testo1_d(dp_testo1_3), .dp_testo2_d(dp_testo2_3), .dp_testo1_sub_d(dp_testo1_sub_3),
        .rsp_vld_d(rsp_vld_3), .rsp_rdy_d(rsp_rdy_3), .rsp_id_d(rsp_id_3),
        .rsp_data_d(rsp_data_3), .busy_d(busy_3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected response word for an operand {testi3,testi2,testi1}.
    function automatic logic [3:0] subd_rsp(input logic [2:0] op);
        logic t1, t2, t3;
        t1 = op[0]; t2 = op[1]; t3 = op[2];
        return {t2, t2, t1 & t3, t1 ^ t2};
    endfunction

    // First valid requester after ptr, modulo N; -1 if none.
    function automatic int m_pick(input logic [N-1:0] v, input int ptr);
        for (int j = 1; j <= N; j++) begin
            if (v[(ptr + j) % N]) return (ptr + j) % N;
        end
        return -1;
    endfunction

    int         m_ptr, m_hold, m_id;
    bit         m_busy, m_rsp;
    logic [2:0] m_op;
    logic [3:0] m_data;

    logic [N-1:0] s_rdy;
    logic         s_rspv, s_busy;
    logic [1:0]   s_id;
    logic [3:0]   s_data;
    logic [2:0]   s_dp;

    task automatic m_reset();
        m_ptr = N - 1; m_hold = 0; m_id = 0;
        m_busy = 0; m_rsp = 0; m_op = '0; m_data = '0;
    endtask

    // One clock cycle: drive, sample, compare against the model, advance the model.
    task automatic cycle(input logic [N-1:0] vld, input logic [3*N-1:0] ops, input logic rdy);
        int k;
        logic [N-1:0] e_rdy;
        @(negedge clk_d);
        req_vld_d = vld; req_op_d = ops; rsp_rdy_d = rdy;
        #1;
        s_rdy = req_rdy_d; s_rspv = rsp_vld_d; s_busy = busy_d;
        s_id = rsp_id_d; s_data = rsp_data_d; s_dp = {dp_testi3_d, dp_testi2_d, dp_testi1_d};
        k = m_busy ? -1 : m_pick(vld, m_ptr);
        e_rdy = '0;
        if (k >= 0) e_rdy[k] = 1'b1;
        chk("req_rdy", s_rdy, e_rdy);
        chk("rsp_vld", s_rspv, m_rsp);
        chk("busy", s_busy, m_busy);
        chk("dp_op", s_dp, m_op);
        if (m_rsp) begin
            chk("rsp_id", s_id, m_id);
            chk("rsp_data", s_data, m_data);
        end
        if (k >= 0) begin
            m_busy = 1; m_hold = HC; m_id = k; m_op = ops[3*k +: 3];
        end else if (m_busy && !m_rsp) begin
            m_hold--;
            if (m_hold == 0) begin
                m_rsp = 1; m_data = subd_rsp(m_op);
            end
        end else if (m_rsp && rdy) begin
            m_rsp = 0; m_busy = 0; m_ptr = m_id;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_d);
        rst_n_d = 1'b0; req_vld_d = '0; rsp_rdy_d = 1'b0;
        m_reset();
        repeat (2) @(negedge clk_d);
        rst_n_d = 1'b1;
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    logic [3*N-1:0] ops;
    logic [N-1:0]   rv;
    logic [3:0]     t4_data;
    logic [1:0]     t4_id;
    int             gq[$];
    int             gc[$];
    int             first;

    initial begin
        rst_n_d = 1'b0; req_vld_d = '0; req_op_d = '0; rsp_rdy_d = 1'b0;
        req_vld_3 = '0; req_op_3 = '0; rsp_rdy_3 = 1'b1;
        m_reset();

        // Reset mid-HOLD
        do_reset();
        ops = {3'b000, 3'b000, 3'b000, 3'b110};
        cycle(4'b0001, ops, 1'b1);
        cycle(4'b0000, ops, 1'b1);
        rst_n_d = 1'b0; req_vld_d = 4'b1111;
        #1;
        chk("t1_rst_rspv", rsp_vld_d, 1'b0);
        chk("t1_rst_busy", busy_d, 1'b0);
        chk("t1_rst_rdy", req_rdy_d, 4'b0000);
        chk("t1_rst_dp", {dp_testi3_d, dp_testi2_d, dp_testi1_d}, 3'b000);
        chk("t1_rst_id", rsp_id_d, 2'd0);
        chk("t1_rst_data", rsp_data_d, 4'd0);
        m_reset();
        repeat (2) @(negedge clk_d);
        req_vld_d = '0;
        rst_n_d = 1'b1;
        repeat (4) cycle(4'b0000, ops, 1'b1);
        cycle(4'b1111, ops, 1'b1);
        chk("t1_first_gnt", s_rdy, 4'b0001);

        // Single request
        do_reset();
        ops = {3'b000, 3'b000, 3'b000, 3'b011};
        cycle(4'b0001, ops, 1'b1);
        chk("t2_gnt", s_rdy, 4'b0001);
        cycle(4'b0000, ops, 1'b1);
        cycle(4'b0000, ops, 1'b1);
        chk("t2_rspv", s_rspv, 1'b1);
        chk("t2_id", s_id, 2'd0);
        chk("t2_data", s_data, 4'b1100);

        // Round-robin with all requesting
        do_reset();
        ops = {3'b101, 3'b010, 3'b111, 3'b001};
        for (int c = 0; c < 15; c++) begin
            cycle(4'b1111, ops, 1'b1);
            if (s_rdy != '0) begin
                gq.push_back(oh_idx(s_rdy));
                gc.push_back(c);
            end
        end
        chk("t3_gnt_cnt", gq.size(), 5);
        for (int i = 0; i < gq.size() && i < 5; i++) begin
            chk("t3_gnt_idx", gq[i], i % 4);
            chk("t3_gnt_cyc", gc[i], 3 * i);
        end

        // Backpressure
        do_reset();
        ops = {3'b000, 3'b100, 3'b111, 3'b000};
        cycle(4'b0010, ops, 1'b0);
        cycle(4'b0000, ops, 1'b0);
        cycle(4'b0100, ops, 1'b0);
        t4_data = s_data; t4_id = s_id;
        chk("t4_rspv0", s_rspv, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cycle(4'b0100, ops, 1'b0);
            chk("t4_vld_hold", s_rspv, 1'b1);
            chk("t4_data_hold", s_data, t4_data);
            chk("t4_id_hold", s_id, t4_id);
            chk("t4_no_gnt", s_rdy, 4'b0000);
            chk("t4_busy", s_busy, 1'b1);
        end
        cycle(4'b0100, ops, 1'b1);
        cycle(4'b0100, ops, 1'b1);
        chk("t4_next_gnt", s_rdy, 4'b0100);

        // Wrap from ptr=3
        do_reset();
        ops = {3'b011, 3'b110, 3'b001, 3'b101};
        cycle(4'b1000, ops, 1'b1);
        cycle(4'b0000, ops, 1'b1);
        cycle(4'b0000, ops, 1'b1);
        cycle(4'b0101, ops, 1'b1);
        chk("t5_gnt0", s_rdy, 4'b0001);
        cycle(4'b0101, ops, 1'b1);
        cycle(4'b0101, ops, 1'b1);
        cycle(4'b0101, ops, 1'b1);
        chk("t5_gnt2", s_rdy, 4'b0100);

        // Randomized traffic
        do_reset();
        rv = '0; ops = '0; s_rdy = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!rv[k]) begin
                    ops[3*k +: 3] = 3'($urandom_range(0, 7));
                    rv[k] = ($urandom_range(0, 3) == 0);
                end else if (s_rdy[k]) begin
                    rv[k] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 7) == 0) begin
                    rv[k] = 1'b0;
                end
            end
            cycle(rv, ops, ($urandom_range(0, 9) < 7));
        end

        // HOLD_CYC=3 instance: latency and operand stability
        do_reset();
        first = -1;
        @(negedge clk_d);
        req_vld_3 = 4'b0001; req_op_3 = {3'b000, 3'b000, 3'b000, 3'b101};
        #1;
        chk("t6_gnt", req_rdy_3, 4'b0001);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_d);
            req_vld_3 = '0;
            #1;
            if (rsp_vld_3 && first < 0) begin
                first = c;
                chk("t6_data", rsp_data_3, subd_rsp(3'b101));
            end
            if (c <= 3) begin
                chk("t6_dp", {dp_testi3_3, dp_testi2_3, dp_testi1_3}, 3'b101);
                chk("t6_early_vld", rsp_vld_3, 1'b0);
            end
        end
        chk("t6_latency", first, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
